// File: rtl/alu_sequencer.sv
// alu_sequencer: fetches operands from a 16x32 register file, drives the external ALU for one cycle,
// writes back and returns a response. Define ALU_SEQ_R0_ZERO_EN to make R0 a hardwired zero.
module alu_sequencer #(
    parameter int DATA_W = 32,
    parameter int REGS   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              InstrValid,
    output logic              InstrReady,
    input  logic [3:0]        InstrOpcode,
    input  logic [3:0]        InstrRd,
    input  logic [3:0]        InstrRs,
    input  logic [3:0]        InstrRt,
    input  logic [15:0]       InstrImm,
    input  logic              InstrImmSel,
    output logic [DATA_W-1:0] OperandA,
    output logic [DATA_W-1:0] OperandB,
    output logic [3:0]        ALUopsel,
    input  logic [DATA_W-1:0] ALUresult,
    input  logic              Overflow,
    input  logic              Equal,
    input  logic              Carry,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [DATA_W-1:0] RespData,
    output logic [2:0]        RespFlags,
    output logic              RespErr
);
    localparam logic [3:0] OP_NOP = 4'b0000, OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_AND = 4'b0101,
                           OP_OR  = 4'b0110, OP_NOT = 4'b0111, OP_XOR = 4'b1000, OP_SLL = 4'b1001,
                           OP_MOV = 4'b1011;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state_q, state_d;
    logic [DATA_W-1:0] rf_q [REGS];
    logic [DATA_W-1:0] opa_q, opb_q, data_q;
    logic [3:0] aluop_q, op_q, rd_q;
    logic [2:0] status_q;
    logic rdy_q, legal_q, err_q;
    logic accept, legal_in, writes, flag_upd, wr_en;
    always_comb begin
        legal_in = InstrOpcode inside {OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_XOR, OP_SLL, OP_MOV};
        accept   = InstrValid && InstrReady;
        writes   = legal_q && (op_q != OP_NOP);
        flag_upd = writes && (op_q != OP_MOV);
`ifdef ALU_SEQ_R0_ZERO_EN
        wr_en    = writes && (rd_q != 4'd0);
`else
        wr_en    = writes;
`endif
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? EXEC : IDLE) :
                  (state_q == EXEC) ? RESP : (RespReady ? IDLE : RESP);
    end
    // rdy_q keeps InstrReady low until the first edge after reset release
    always_comb begin
        InstrReady = rdy_q && (state_q == IDLE);
        RespValid  = (state_q == RESP);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) rf_q[i] <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            data_q   <= '0;
            aluop_q  <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            status_q <= '0;
            rdy_q    <= 1'b0;
            legal_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (accept) begin
                opa_q   <= rf_q[InstrRs];
                opb_q   <= InstrImmSel ? {{(DATA_W-16){1'b0}}, InstrImm} : rf_q[InstrRt];
                aluop_q <= legal_in ? InstrOpcode : OP_NOP;
                op_q    <= InstrOpcode;
                rd_q    <= InstrRd;
                legal_q <= legal_in;
            end
            if (state_q == EXEC) begin
                if (wr_en) rf_q[rd_q] <= ALUresult;
                if (flag_upd) status_q <= {Overflow, Carry, Equal};
                data_q <= writes ? ALUresult : '0;
                err_q  <= !legal_q;
            end
        end
    end
    always_comb begin
        OperandA  = opa_q;
        OperandB  = opb_q;
        ALUopsel  = aluop_q;
        RespData  = data_q;
        RespFlags = status_q;
        RespErr   = err_q;
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed checks of alu_sequencer against a behavioural ALU stand-in.
module tb_alu_sequencer;
    logic clk = 0, rst_n = 0;
    logic InstrValid = 0, InstrImmSel = 0, RespReady = 0;
    logic [3:0] InstrOpcode = 0, InstrRd = 0, InstrRs = 0, InstrRt = 0;
    logic [15:0] InstrImm = 0;
    logic InstrReady, RespValid, RespErr;
    logic [31:0] OperandA, OperandB, RespData, ALUresult;
    logic [3:0] ALUopsel;
    logic [2:0] RespFlags;
    logic Overflow, Equal, Carry;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .InstrValid(InstrValid), .InstrReady(InstrReady),
        .InstrOpcode(InstrOpcode), .InstrRd(InstrRd), .InstrRs(InstrRs), .InstrRt(InstrRt),
        .InstrImm(InstrImm), .InstrImmSel(InstrImmSel), .OperandA(OperandA), .OperandB(OperandB),
        .ALUopsel(ALUopsel), .ALUresult(ALUresult), .Overflow(Overflow), .Equal(Equal), .Carry(Carry),
        .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData), .RespFlags(RespFlags),
        .RespErr(RespErr)
    );

    // ALU stand-in: carry is the carry-out of A+B or A+~B+1
    always_comb begin
        logic [32:0] s;
        s = '0;
        Carry = 1'b0;
        Overflow = 1'b0;
        case (ALUopsel)
            4'd1: s = {1'b0, OperandA} + {1'b0, OperandB};
            4'd2: s = {1'b0, OperandA} + {1'b0, ~OperandB} + 33'd1;
            4'd5: s = {1'b0, OperandA & OperandB};
            4'd6: s = {1'b0, OperandA | OperandB};
            4'd7: s = {1'b0, ~OperandA};
            4'd8: s = {1'b0, OperandA ^ OperandB};
            4'd9: s = {1'b0, OperandA << OperandB[4:0]};
            4'd11: s = {1'b0, OperandB};
            default: s = '0;
        endcase
        ALUresult = s[31:0];
        if (ALUopsel == 4'd1 || ALUopsel == 4'd2) begin
            Carry = s[32];
            Overflow = (ALUopsel == 4'd1) ? (OperandA[31] == OperandB[31]) && (s[31] != OperandA[31])
                                          : (OperandA[31] != OperandB[31]) && (s[31] != OperandA[31]);
        end
        Equal = (OperandA == OperandB);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, rd, rs, rt, input logic [15:0] imm, input logic sel);
        InstrOpcode = op; InstrRd = rd; InstrRs = rs; InstrRt = rt; InstrImm = imm; InstrImmSel = sel;
        InstrValid = 1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (InstrReady !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_ready_timeout"}, 32'(n < 20), 32'd1);
    endtask

    task automatic run(input string tag, input logic [3:0] op, rd, rs, rt, input logic [15:0] imm,
                       input logic sel, input logic [3:0] exp_aop, input logic [31:0] exp_d,
                       input logic [2:0] exp_f, input logic exp_e);
        @(negedge clk);
        drive(op, rd, rs, rt, imm, sel);
        wait_ready(tag);
        @(posedge clk); #1 InstrValid = 0;
        chk({tag, "_aluop"}, 32'(ALUopsel), 32'(exp_aop));
        chk({tag, "_valid_early"}, 32'(RespValid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 32'(RespValid), 32'd1);
        chk({tag, "_data"}, RespData, exp_d);
        chk({tag, "_flags"}, 32'(RespFlags), 32'(exp_f));
        chk({tag, "_err"}, 32'(RespErr), 32'(exp_e));
        @(negedge clk) RespReady = 1;
        @(posedge clk); #1 RespReady = 0;
        chk({tag, "_done"}, 32'(RespValid), 32'd0);
    endtask

    task automatic check_zero_outs(input string tag);
        chk({tag, "_ready"}, 32'(InstrReady), 32'd0);
        chk({tag, "_rvalid"}, 32'(RespValid), 32'd0);
        chk({tag, "_rdata"}, RespData, 32'd0);
        chk({tag, "_rflags"}, 32'(RespFlags), 32'd0);
        chk({tag, "_rerr"}, 32'(RespErr), 32'd0);
        chk({tag, "_opa"}, OperandA, 32'd0);
        chk({tag, "_opb"}, OperandB, 32'd0);
        chk({tag, "_aop"}, 32'(ALUopsel), 32'd0);
    endtask

    initial begin
        #12 check_zero_outs("reset");
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1 chk("ready_after_reset", 32'(InstrReady), 32'd1);
        // MOVI R1,5 ; MOVI R2,7 ; ADD R3,R1,R2 ; readback R3
        run("movi_r1", 4'd11, 4'd1, 4'd0, 4'd0, 16'd5, 1, 4'd11, 32'd5, 3'b000, 0);
        run("movi_r2", 4'd11, 4'd2, 4'd0, 4'd0, 16'd7, 1, 4'd11, 32'd7, 3'b000, 0);
        run("add_r3", 4'd1, 4'd3, 4'd1, 4'd2, 16'd0, 0, 4'd1, 32'd12, 3'b000, 0);
        run("rd_r3", 4'd11, 4'd15, 4'd0, 4'd3, 16'd0, 0, 4'd11, 32'd12, 3'b000, 0);
        // SLL and SUB with signed overflow
        run("movi_r1b", 4'd11, 4'd1, 4'd0, 4'd0, 16'd1, 1, 4'd11, 32'd1, 3'b000, 0);
        run("slli", 4'd9, 4'd1, 4'd1, 4'd0, 16'd31, 1, 4'd9, 32'h8000_0000, 3'b000, 0);
        run("subi", 4'd2, 4'd2, 4'd1, 4'd0, 16'd1, 1, 4'd2, 32'h7FFF_FFFF, 3'b110, 0);
        // Logic ops; same-register operands read the pre-write value
        run("xor_self", 4'd8, 4'd3, 4'd3, 4'd3, 16'd0, 0, 4'd8, 32'd0, 3'b001, 0);
        run("not_r2", 4'd7, 4'd6, 4'd2, 4'd2, 16'd0, 0, 4'd7, 32'h8000_0000, 3'b001, 0);
        run("andi", 4'd5, 4'd7, 4'd2, 4'd0, 16'hF0F0, 1, 4'd5, 32'h0000_F0F0, 3'b000, 0);
        run("ori", 4'd6, 4'd7, 4'd7, 4'd0, 16'h0F0F, 1, 4'd6, 32'h0000_FFFF, 3'b000, 0);
        // Illegal opcode leaves RF and status untouched
        run("movi_r4", 4'd11, 4'd4, 4'd0, 4'd0, 16'd9, 1, 4'd11, 32'd9, 3'b000, 0);
        run("illegal", 4'd15, 4'd4, 4'd4, 4'd4, 16'd0, 0, 4'd0, 32'd0, 3'b000, 1);
        run("rd_r4", 4'd11, 4'd15, 4'd0, 4'd4, 16'd0, 0, 4'd11, 32'd9, 3'b000, 0);
        run("nop", 4'd0, 4'd4, 4'd1, 4'd2, 16'd0, 0, 4'd0, 32'd0, 3'b000, 0);
        run("sub_set_flags", 4'd2, 4'd8, 4'd1, 4'd0, 16'd1, 1, 4'd2, 32'h7FFF_FFFF, 3'b110, 0);
        run("nop_keeps_flags", 4'd0, 4'd0, 4'd0, 4'd0, 16'd0, 0, 4'd0, 32'd0, 3'b110, 0);
        // Back-pressure: ADD R6,R1,R2 = 0x80000000+0x7FFFFFFF, next instruction held meanwhile
        @(negedge clk);
        drive(4'd1, 4'd6, 4'd1, 4'd2, 16'd0, 0);
        wait_ready("bp");
        @(posedge clk); #1 drive(4'd11, 4'd9, 4'd0, 4'd0, 16'h55, 1);
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(RespValid), 32'd1);
            chk("bp_data", RespData, 32'hFFFF_FFFF);
            chk("bp_ready", 32'(InstrReady), 32'd0);
        end
        chk("bp_flags", 32'(RespFlags), 32'd0);
        RespReady = 1;
        InstrValid = 0;
        @(posedge clk); #1 RespReady = 0;
        chk("bp_release_valid", 32'(RespValid), 32'd0);
        chk("bp_release_ready", 32'(InstrReady), 32'd1);
        run("rd_r9", 4'd11, 4'd15, 4'd0, 4'd9, 16'd0, 0, 4'd11, 32'd0, 3'b000, 0);
        // Reset during EXEC of ADD R5
        @(negedge clk);
        drive(4'd1, 4'd5, 4'd1, 4'd1, 16'd0, 0);
        wait_ready("mid");
        @(posedge clk); #1 InstrValid = 0;
        chk("mid_in_exec_aop", 32'(ALUopsel), 32'd1);
        rst_n = 0;
        #1 check_zero_outs("mid_reset");
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1 chk("mid_ready", 32'(InstrReady), 32'd1);
        run("rd_r5", 4'd11, 4'd15, 4'd0, 4'd5, 16'd0, 0, 4'd11, 32'd0, 3'b000, 0);
        run("rd_r1", 4'd11, 4'd15, 4'd0, 4'd1, 16'd0, 0, 4'd11, 32'd0, 3'b000, 0);
        run("post_movi", 4'd11, 4'd1, 4'd0, 4'd0, 16'd3, 1, 4'd11, 32'd3, 3'b000, 0);
        run("post_add", 4'd1, 4'd5, 4'd1, 4'd1, 16'd0, 0, 4'd1, 32'd6, 3'b001, 0);
        // Register 0 behaviour depends on the build option
        run("movi_r0", 4'd11, 4'd0, 4'd0, 4'd0, 16'h1234, 1, 4'd11, 32'h1234, 3'b001, 0);
`ifdef ALU_SEQ_R0_ZERO_EN
        run("add_r0", 4'd1, 4'd1, 4'd0, 4'd0, 16'd0, 0, 4'd1, 32'd0, 3'b001, 0);
`else
        run("add_r0", 4'd1, 4'd1, 4'd0, 4'd0, 16'd0, 0, 4'd1, 32'h2468, 3'b001, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
